// File: rtl/mix_col_seq_pkg.sv
// Shared types and constants for the sequential AES MixColumns block.
// Holds the FSM encoding, the AES reduction polynomial and the GF(2^8) xtime helper.
package mix_col_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         STATE_W  = 128;
  localparam int         COL_W    = 32;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_col_seq_if.sv
// Upstream/downstream handshake bundle of mix_col_seq.
// The slave modport is the block's view; the master modport is the environment's view.
interface mix_col_seq_if;
  import mix_col_seq_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_data;
  logic               in_bypass;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_data;
  logic               busy;

  modport slave (
    input  in_valid, in_data, in_bypass, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, in_bypass, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/mix_col_seq_mixcol.sv
// Single-column AES MixColumns mixer (purely combinational).
// Row 0 of the column is i_x0 / o_y0.
module mixCol
  import mix_col_seq_pkg::*;
(
  input  logic [7:0] i_x0,
  input  logic [7:0] i_x1,
  input  logic [7:0] i_x2,
  input  logic [7:0] i_x3,
  output logic [7:0] o_y0,
  output logic [7:0] o_y1,
  output logic [7:0] o_y2,
  output logic [7:0] o_y3
);

  logic [7:0] w_2x0, w_2x1, w_2x2, w_2x3;
  logic [7:0] w_3x0, w_3x1, w_3x2, w_3x3;

  assign w_2x0 = xtime(i_x0);
  assign w_2x1 = xtime(i_x1);
  assign w_2x2 = xtime(i_x2);
  assign w_2x3 = xtime(i_x3);

  // 3x = 2x ^ x in GF(2^8)
  assign w_3x0 = w_2x0 ^ i_x0;
  assign w_3x1 = w_2x1 ^ i_x1;
  assign w_3x2 = w_2x2 ^ i_x2;
  assign w_3x3 = w_2x3 ^ i_x3;

  assign o_y0 = w_2x0 ^ w_3x1 ^ i_x2  ^ i_x3;
  assign o_y1 = i_x0  ^ w_2x1 ^ w_3x2 ^ i_x3;
  assign o_y2 = i_x0  ^ i_x1  ^ w_2x2 ^ w_3x3;
  assign o_y3 = w_3x0 ^ i_x1  ^ i_x2  ^ w_2x3;

endmodule

// File: rtl/mix_col_seq.sv
// Sequential AES MixColumns: one shared column mixer processes the four columns
// of a 128-bit state over four cycles; a bypass flag passes the state through unchanged.
module mix_col_seq
  import mix_col_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mix_col_seq_if.slave  bus
);

  state_e             r_state;
  logic [1:0]         r_col;
  logic               r_bypass;
  logic [STATE_W-1:0] r_work;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [6:0]         w_col_base;
  logic [COL_W-1:0]   w_col_in;
  logic [COL_W-1:0]   w_col_out;

  // Column c sits at bits [127-32c -: 32], i.e. base offset (3-c)*32.
  assign w_col_base = {~r_col, 5'b00000};
  assign w_col_in   = r_work[w_col_base +: COL_W];

  mixCol u_mix (
    .i_x0 (w_col_in[31:24]),
    .i_x1 (w_col_in[23:16]),
    .i_x2 (w_col_in[15:8]),
    .i_x3 (w_col_in[7:0]),
    .o_y0 (w_col_out[31:24]),
    .o_y1 (w_col_out[23:16]),
    .o_y2 (w_col_out[15:8]),
    .o_y3 (w_col_out[7:0])
  );

  // Control FSM with registered handshake flags and in-place column write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_col       <= 2'd0;
      r_bypass    <= 1'b0;
      r_work      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_work     <= bus.in_data;
            r_bypass   <= bus.in_bypass;
            r_col      <= 2'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (bus.in_bypass) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= ST_MIX;
              r_out_valid <= 1'b0;
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_MIX: begin
          if (!r_bypass) begin
            r_work[w_col_base +: COL_W] <= w_col_out;
          end else begin
            r_work <= r_work;
          end
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_state <= ST_MIX;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_col       <= 2'd0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_work;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mix_col_seq.sv
// Scoreboard testbench for mix_col_seq: directed vectors, backpressure,
// mid-operation reset and randomised back-to-back traffic.
module tb_mix_col_seq;
  import mix_col_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mix_col_seq_if bus();

  mix_col_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           n_sent   = 0;
  int           n_recv   = 0;
  logic [127:0] exp_q[$];
  int           lat_q[$];
  logic         rnd_rdy  = 1'b0;
  logic         prev_ov  = 1'b0;

  localparam logic [127:0] V28_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V28_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V29_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V29_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] V30_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply used by the reference model.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [31:0]  x;
    logic [7:0]   x0, x1, x2, x3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      x  = s[127-32*c -: 32];
      x0 = x[31:24]; x1 = x[23:16]; x2 = x[15:8]; x3 = x[7:0];
      r[127-32*c -: 32] = {gmul(x0, 8'd2) ^ gmul(x1, 8'd3) ^ x2 ^ x3,
                           x0 ^ gmul(x1, 8'd2) ^ gmul(x2, 8'd3) ^ x3,
                           x0 ^ x1 ^ gmul(x2, 8'd2) ^ gmul(x3, 8'd3),
                           gmul(x0, 8'd3) ^ x1 ^ x2 ^ gmul(x3, 8'd2)};
    end
    return r;
  endfunction

  // Monitor: latency on out_valid rise, data on every output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !prev_ov) begin
        if (lat_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_valid: got out_valid=1 at cycle %0d expected no pending request", cyc);
        end else begin
          check("latency", cyc, lat_q.pop_front());
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_recv++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got %h expected no output", bus.out_data);
        end else begin
          check("out_data", bus.out_data, exp_q.pop_front());
        end
      end
      prev_ov = bus.out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [127:0] d, input logic byp, input logic [127:0] exp_v);
    logic r;
    logic ok;
    ok = 1'b0;
    bus.in_data   = d;
    bus.in_bypass = byp;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        exp_q.push_back(exp_v);
        lat_q.push_back(cyc + (byp ? 0 : 4));
        n_sent++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.in_data   = ~d;
    bus.in_bypass = ~byp;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 300 cycles expected accept");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_data", bus.out_data, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with downstream always ready
    bus.out_ready = 1'b1;
    send(V28_IN, 1'b0, V28_OUT);
    send(V29_IN, 1'b0, V29_OUT);
    send(V30_IN, 1'b1, V30_IN);
    wait_drain();

    // Backpressure: hold output 10 cycles while a second offer is ignored
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(V29_IN, 1'b0, V29_OUT);
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    check("bp_valid_seen", bus.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.in_data   = V30_IN;
      bus.in_bypass = 1'b1;
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, V29_OUT);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_busy", bus.busy, 1);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_in_ready_after", bus.in_ready, 1);
    check("bp_out_valid_after", bus.out_valid, 0);
    wait_drain();

    // Reset while MIX is on column 2
    @(posedge clk); #1;
    send(V28_IN, 1'b0, V28_OUT);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    n_sent--;
    @(negedge clk);
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_out_data", bus.out_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("mrst_rel_out_valid", bus.out_valid, 0);
    check("mrst_rel_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    send(V29_IN, 1'b0, V29_OUT);
    wait_drain();

    // Random back-to-back traffic against the reference model
    rnd_rdy = 1'b1;
    for (int n = 0; n < 100; n++) begin
      logic [127:0] d;
      logic         b;
      d = {$urandom, $urandom, $urandom, $urandom};
      b = ($urandom_range(0, 3) == 0);
      send(d, b, b ? d : ref_mix(d));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_drain();
    rnd_rdy = 1'b0;
    check("no_drop_dup", n_recv, n_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
